butterfly_divider: RTL and testbench

Sequential signed integer divider, the inverse operation of the butterfly datapath's combinational signed multiplier. It takes a two's-complement dividend and divisor, converts both to magnitudes, and runs a radix-2 restoring division, one quotient bit per cycle. It then re-applies signs and returns a truncated-toward-zero quotient and a remainder. It sits beside the multiplier in the filter/butterfly datapath, where gain normalisation and scaling need a divide, and uses a valid/ready handshake on both sides.

---
 rtl/butterfly_divider.sv | 156 +++++++++++++++
 tb/tb_butterfly_divider.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_divider.sv
// Sequential signed divider for the butterfly datapath.
// Radix-2 restoring division on magnitudes, signs re-applied at the end.
module butterfly_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] xDividend,
    input  logic [WIDTH-1:0] xDivisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] xQuotient,
    output logic [WIDTH-1:0] xRemainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0] pr_q, pr_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic           sgnq_q, sgnq_d;
    logic           sgnr_q, sgnr_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shift_w;
    logic [WIDTH+1:0] trial_w;
    logic [WIDTH-1:0] r_mag;

    // |MIN_NEG| wraps to itself, which is the correct unsigned magnitude
    assign a_mag = xDividend[WIDTH-1] ? -xDividend : xDividend;
    assign b_mag = xDivisor[WIDTH-1] ? -xDivisor : xDivisor;

    assign shift_w = {pr_q[WIDTH-1:0], dq_q[WIDTH-1]};
    assign trial_w = {1'b0, shift_w} - {2'b00, dv_q};
    assign r_mag   = pr_q[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dq_q    <= '0;
            dv_q    <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dq_q    <= dq_d;
            dv_q    <= dv_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dq_d    = dq_q;
        dv_d    = dv_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sgnq_d = xDividend[WIDTH-1] ^ xDivisor[WIDTH-1];
                    sgnr_d = xDividend[WIDTH-1];
                    dq_d   = a_mag;
                    dv_d   = b_mag;
                    pr_d   = '0;
                    cnt_d  = '0;
                    if (xDivisor == '0) begin
                        quo_d   = xDividend[WIDTH-1] ? MIN_NEG : MAX_POS;
                        rem_d   = xDividend;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else if (xDividend == MIN_NEG && xDivisor == '1) begin
                        quo_d   = MAX_POS;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                // A negative trial restores the shifted remainder
                pr_d  = trial_w[WIDTH+1] ? shift_w : trial_w[WIDTH:0];
                dq_d  = {dq_q[WIDTH-2:0], ~trial_w[WIDTH+1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = sgnq_q ? -dq_q : dq_q;
                rem_d   = sgnr_q ? -r_mag : r_mag;
                dbz_d   = 1'b0;
                ovf_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign xQuotient   = quo_q;
    assign xRemainder  = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_butterfly_divider.sv
// Directed-vector bench for butterfly_divider.
// Latency is counted in clock edges after the accept edge.
module tb_butterfly_divider;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] xDividend;
    logic [15:0] xDivisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] xQuotient;
    logic [15:0] xRemainder;
    logic        div_by_zero;
    logic        overflow;

    int n_cmp;
    int n_bad;

    butterfly_divider #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .xDividend  (xDividend),
        .xDivisor   (xDivisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xQuotient  (xQuotient),
        .xRemainder (xRemainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: issue one division, wait for the result, retire it.
    task automatic run_case(input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] q, output logic [15:0] r,
                            output logic dz, output logic ov,
                            output int lat, output bit to);
        @(negedge clk);
        in_valid  = 1'b1;
        xDividend = a;
        xDivisor  = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        xDividend = 16'hA5A5;
        xDivisor  = 16'h0003;
        lat = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
            lat++;
        end
        q  = xQuotient;
        r  = xRemainder;
        dz = div_by_zero;
        ov = overflow;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, div_by_zero, overflow} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctrl: rdy/vld/dz/ov=%b expected 1000",
                     {in_ready, out_valid, div_by_zero, overflow});
        end
        n_cmp++;
        if (xQuotient !== 16'h0000 || xRemainder !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_data: q=%h r=%h expected 0000 0000",
                     xQuotient, xRemainder);
        end
    endtask

    task automatic test_basic();
        logic [15:0] q, r;
        logic dz, ov;
        int lat;
        bit to;
        run_case(16'd100, 16'd7, q, r, dz, ov, lat, to);
        n_cmp++;
        if (to || q !== 16'd14 || r !== 16'd2 || {dz, ov} !== 2'b00 || lat !== 17) begin
            n_bad++;
            $display("FAIL basic_100_7: to=%0b q=%h r=%h dz=%b ov=%b lat=%0d expected q=000e r=0002 dz=0 ov=0 lat=17",
                     to, q, r, dz, ov, lat);
        end
    endtask

    task automatic test_signs();
        logic [15:0] ta[3] = '{16'hFF9C, 16'h0064, 16'hFF9C};
        logic [15:0] tb[3] = '{16'h0007, 16'hFFF9, 16'hFFF9};
        logic [15:0] eq[3] = '{16'hFFF2, 16'hFFF2, 16'h000E};
        logic [15:0] er[3] = '{16'hFFFE, 16'h0002, 16'hFFFE};
        logic [15:0] q, r;
        logic dz, ov;
        int lat;
        bit to;
        for (int i = 0; i < 3; i++) begin
            run_case(ta[i], tb[i], q, r, dz, ov, lat, to);
            n_cmp++;
            if (to || q !== eq[i] || r !== er[i] || {dz, ov} !== 2'b00 || lat !== 17) begin
                n_bad++;
                $display("FAIL signs_%0d: to=%0b q=%h r=%h dz=%b ov=%b lat=%0d expected q=%h r=%h dz=0 ov=0 lat=17",
                         i, to, q, r, dz, ov, lat, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [15:0] ta[2] = '{16'h0005, 16'hFFFB};
        logic [15:0] eq[2] = '{16'h7FFF, 16'h8000};
        logic [15:0] er[2] = '{16'h0005, 16'hFFFB};
        logic [15:0] q, r;
        logic dz, ov;
        int lat;
        bit to;
        for (int i = 0; i < 2; i++) begin
            run_case(ta[i], 16'h0000, q, r, dz, ov, lat, to);
            n_cmp++;
            if (to || q !== eq[i] || r !== er[i] || {dz, ov} !== 2'b10 || lat !== 0) begin
                n_bad++;
                $display("FAIL divzero_%0d: to=%0b q=%h r=%h dz=%b ov=%b lat=%0d expected q=%h r=%h dz=1 ov=0 lat=0",
                         i, to, q, r, dz, ov, lat, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_edge();
        logic [15:0] ta[7] = '{16'h8000, 16'h8000, 16'h0007, 16'h7FFF,
                               16'h8000, 16'h8000, 16'hFFF9};
        logic [15:0] tb[7] = '{16'hFFFF, 16'h0001, 16'h0064, 16'h8000,
                               16'h8000, 16'h0002, 16'h0064};
        logic [15:0] eq[7] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h0000,
                               16'h0001, 16'hC000, 16'h0000};
        logic [15:0] er[7] = '{16'h0000, 16'h0000, 16'h0007, 16'h7FFF,
                               16'h0000, 16'h0000, 16'hFFF9};
        logic [1:0]  ef[7] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        int          el[7] = '{0, 17, 17, 17, 17, 17, 17};
        logic [15:0] q, r;
        logic dz, ov;
        int lat;
        bit to;
        for (int i = 0; i < 7; i++) begin
            run_case(ta[i], tb[i], q, r, dz, ov, lat, to);
            n_cmp++;
            if (to || q !== eq[i] || r !== er[i] || {dz, ov} !== ef[i] || lat !== el[i]) begin
                n_bad++;
                $display("FAIL edge_%0d: to=%0b q=%h r=%h dz/ov=%b lat=%0d expected q=%h r=%h dz/ov=%b lat=%0d",
                         i, to, q, r, {dz, ov}, lat, eq[i], er[i], ef[i], el[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] q, r;
        logic dz, ov;
        int lat;
        bit to;
        @(negedge clk);
        in_valid  = 1'b1;
        xDividend = 16'd1234;
        xDivisor  = 16'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                to = 1'b0;
                break;
            end
            @(posedge clk);
        end
        n_cmp++;
        if (to || xQuotient !== 16'd123 || xRemainder !== 16'd4) begin
            n_bad++;
            $display("FAIL bp_result: to=%0b q=%h r=%h expected q=007b r=0004",
                     to, xQuotient, xRemainder);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                xQuotient !== 16'd123 || xRemainder !== 16'd4) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: rdy=%b vld=%b q=%h r=%h expected rdy=0 vld=1 q=007b r=0004",
                         i, in_ready, out_valid, xQuotient, xRemainder);
            end
            in_valid  = ~in_valid;
            xDividend = 16'd50 + 16'(i);
            xDivisor  = 16'd5;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || xQuotient !== 16'd123) begin
            n_bad++;
            $display("FAIL bp_release: rdy=%b vld=%b q=%h expected rdy=1 vld=0 q=007b",
                     in_ready, out_valid, xQuotient);
        end
        run_case(16'd50, 16'd5, q, r, dz, ov, lat, to);
        n_cmp++;
        if (to || q !== 16'd10 || r !== 16'd0 || {dz, ov} !== 2'b00 || lat !== 17) begin
            n_bad++;
            $display("FAIL bp_next: to=%0b q=%h r=%h dz/ov=%b lat=%0d expected q=000a r=0000 dz/ov=00 lat=17",
                     to, q, r, {dz, ov}, lat);
        end
    endtask

    task automatic test_reset_during_div();
        logic [15:0] q, r;
        logic dz, ov;
        int lat;
        bit to;
        bit seen;
        @(negedge clk);
        in_valid  = 1'b1;
        xDividend = 16'd30000;
        xDivisor  = 16'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_div: rdy=%b vld=%b expected rdy=0 vld=0",
                     in_ready, out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            xQuotient !== 16'h0000 || xRemainder !== 16'h0000 ||
            {div_by_zero, overflow} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_mid: rdy=%b vld=%b q=%h r=%h dz/ov=%b expected rdy=1 vld=0 q=0000 r=0000 dz/ov=00",
                     in_ready, out_valid, xQuotient, xRemainder,
                     {div_by_zero, overflow});
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_discard: out_valid seen=%b expected 0", seen);
        end
        run_case(16'd1000, 16'd3, q, r, dz, ov, lat, to);
        n_cmp++;
        if (to || q !== 16'd333 || r !== 16'd1 || {dz, ov} !== 2'b00 || lat !== 17) begin
            n_bad++;
            $display("FAIL rst_fresh: to=%0b q=%h r=%h dz/ov=%b lat=%0d expected q=014d r=0001 dz/ov=00 lat=17",
                     to, q, r, {dz, ov}, lat);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        xDividend = 16'h0000;
        xDivisor  = 16'h0000;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_edge();
        test_backpressure();
        test_reset_during_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
